ovl_sem_edge_sequencer: RTL and testbench
=========================================

# ovl_sem_edge_sequencer

Scheduler for OVL semantic benches. It time-shares one edge-qualified stimulus pair (`sampling_event`, `test_expr`) across `NUM_CHK` OVL checker instances in round-robin order. For each checker it re-resets the shared checker reset, drives a rising sampling edge with good or deliberately bad `test_expr`, then watches that checker's `fire` inside a fixed window. A sticky per-checker mismatch mask and a final `pass` are reported, so one top-level wrapper can sweep many checkers in a single run.

## Interface
- `NUM_CHK`, 4: number of checkers sequenced; must be ≥1.
- `RST_CYCLES`, 2: cycles `chk_rst_n` is held low per checker; must be ≥1.
- `WAIT_CYCLES`, 3: fire-observation cycles after the edge; must be ≥1.
- `clk` input, 1: sole clock, rising edge.
- `reset` input, 1: asynchronous, active-high.
- `start` input, 1: begins a sweep; honoured only in IDLE or DONE.
- `inject` input, NUM_CHK: per checker, 1 = drive failing `test_expr` (fire expected). Latched when `start` is accepted.
- `chk_fire` input, NUM_CHK: `fire` bit 0 of each checker.
- `chk_rst_n` output, 1: shared checker reset, active-low (OVL convention).
- `chk_enable` output, NUM_CHK: one-hot enable of the selected checker; all zero outside a sweep.
- `sampling_event` output, 1: shared sampling event.
- `test_expr` output, 1: shared test expression.
- `cur_idx` output, max(1,$clog2(NUM_CHK)): index of the selected checker.
- `busy` output, 1: sweep in progress.
- `done` output, 1: sweep complete; held until the next `start`.
- `pass` output, 1: valid while `done`; equals `fail_mask == 0`.
- `fail_mask` output, NUM_CHK: sticky per-checker mismatch flags.

## Operation
- FSM states: IDLE, RST, PRE, EDGE, WAIT, NEXT, DONE.
- IDLE/DONE with `start`=1 → RST. Action on acceptance: `inject` latched, `fail_mask` cleared, `cur_idx`=0, `done` cleared.
- RST: `chk_rst_n`=0 for RST_CYCLES cycles, then → PRE.
- PRE: one cycle, `sampling_event`=0. Guarantees a 0→1 transition. → EDGE.
- EDGE: one cycle, `sampling_event`=1, `test_expr` = ~inject_latched[cur_idx]. → WAIT.
- WAIT: WAIT_CYCLES cycles, `sampling_event`=0, `test_expr`=1. → NEXT.
- NEXT: one cycle. Compare the observed value with the expected value and set `fail_mask[cur_idx]` on mismatch.
  - observed = OR of `chk_fire[cur_idx]` over all EDGE and WAIT cycles.
  - expected = inject_latched[cur_idx].
  - If cur_idx == NUM_CHK-1 → DONE; else cur_idx+1 → RST.
- DONE: `done`=1, `busy`=0. `fail_mask` and `pass` are held.
- Outside RST, `chk_rst_n`=1. Outside EDGE, `test_expr`=1.
- `chk_enable[cur_idx]`=1 in RST through NEXT.
- `start` in any state other than IDLE or DONE is ignored.
- `chk_fire` of unselected checkers is ignored unless the configured feature is enabled.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `chk_rst_n`=0, `chk_enable`=0, `sampling_event`=0, `test_expr`=1, `cur_idx`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0.
- After `reset` deasserts, the FSM sits in IDLE with `chk_rst_n`=1.
- Per-checker slot length is RST_CYCLES+WAIT_CYCLES+3 cycles.
- `done` rises NUM_CHK×slot + 1 cycles after the edge that accepts `start`.
- `chk_fire` is sampled in the same cycle it is presented; there is no input synchronisation.
- A fire during RST or PRE is not counted.
- Asserting `reset` mid-sweep aborts immediately to reset values. No partial `fail_mask` survives.
- The cycle counter is wide enough for max(RST_CYCLES, WAIT_CYCLES) and wraps to 0 on each state entry.

## Configuration
- `OVL_SEM_SEQ_SPURIOUS_CHK_EN` defined:
  - During EDGE and WAIT, any `chk_fire[j]` with j ≠ cur_idx sets `fail_mask[j]`.
  - Catches checkers that fire while disabled.
- `OVL_SEM_SEQ_SPURIOUS_CHK_EN` undefined:
  - Unselected fires are ignored.
  - `fail_mask[j]` is written only in checker j's NEXT state.

## Test plan
All scenarios use NUM_CHK=4, RST_CYCLES=2, WAIT_CYCLES=3 (slot of 8 cycles).
- Clean sweep: `inject`=0, model checkers never fire, `start` pulse → `done` after 33 cycles, `pass`=1, `fail_mask`=0.
- Expected fires: `inject`=4'b0101, models fire 1 cycle after EDGE when `test_expr`=0 → `pass`=1, `fail_mask`=0.
- Missed fire: `inject`=4'b0010, checker 1 never fires → `fail_mask`=4'b0010, `pass`=0.
- Spurious fire: checker 3 selected, `inject`=0, fire asserted in the second WAIT cycle → `fail_mask[3]`=1.
- With the macro defined, checker 2 fires while checker 0 is selected → `fail_mask[2]`=1. Without the macro → `fail_mask`=0.
- Reset mid-sweep: `reset` raised in checker 2's WAIT → all outputs at reset values next cycle. A subsequent `start` completes in 33 cycles.

Source files
------------

// File: rtl/ovl_sem_edge_sequencer_if.sv
// Sweep control/status and shared OVL checker stimulus bus for ovl_sem_edge_sequencer.
// The master modport is the sequencer side; the slave modport is the environment/bench side.
interface ovl_sem_edge_sequencer_if #(
  parameter int NUM_CHK = 4,
  parameter int IDX_W   = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
);
  // start is a one-cycle request sampled on the rising clock and accepted only
  // while busy=0; inject is captured on that same edge, and done/pass/fail_mask
  // then hold until the next accepted start.
  logic               start;
  logic [NUM_CHK-1:0] inject;
  logic [NUM_CHK-1:0] chk_fire;
  logic               chk_rst_n;
  logic [NUM_CHK-1:0] chk_enable;
  logic               sampling_event;
  logic               test_expr;
  logic [IDX_W-1:0]   cur_idx;
  logic               busy;
  logic               done;
  logic               pass;
  logic [NUM_CHK-1:0] fail_mask;
  logic [2:0]         state_dbg;

  modport master (
    input  start, inject, chk_fire,
    output chk_rst_n, chk_enable, sampling_event, test_expr, cur_idx,
           busy, done, pass, fail_mask, state_dbg
  );

  modport slave (
    output start, inject, chk_fire,
    input  chk_rst_n, chk_enable, sampling_event, test_expr, cur_idx,
           busy, done, pass, fail_mask, state_dbg
  );
endinterface

// File: rtl/ovl_sem_edge_sequencer.sv
// Round-robin OVL checker sweep: re-reset, drive one sampling edge, watch fire, record mismatches.
// Define OVL_SEM_SEQ_SPURIOUS_CHK_EN to also flag unselected checkers that fire during EDGE/WAIT.
module ovl_sem_edge_sequencer #(
  parameter int NUM_CHK     = 4,
  parameter int RST_CYCLES  = 2,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  ovl_sem_edge_sequencer_if.master bus
);
  localparam int IDX_W   = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;
  localparam int MAX_CYC = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHK - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

`ifdef OVL_SEM_SEQ_SPURIOUS_CHK_EN
  localparam bit SPURIOUS_EN = 1'b1;
`else
  localparam bit SPURIOUS_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_PRE, S_EDGE, S_WAIT, S_NEXT, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_CHK-1:0] inject_q, inject_d;
  logic               seen_q, seen_d;
  logic [NUM_CHK-1:0] fail_mask_q, fail_mask_d;

  logic               chk_rst_n_q;
  logic [NUM_CHK-1:0] chk_enable_q;
  logic               sampling_event_q;
  logic               test_expr_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;

  logic               active_d;
  logic               stay_done;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    inject_d    = inject_q;
    seen_d      = seen_q;
    fail_mask_d = fail_mask_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d     = S_RST;
          inject_d    = bus.inject;
          fail_mask_d = '0;
          idx_d       = '0;
        end
      end
      S_RST: begin
        if (cnt_q == RST_LAST) state_d = S_PRE;
      end
      S_PRE: begin
        state_d = S_EDGE;
        seen_d  = 1'b0;
      end
      S_EDGE: begin
        state_d = S_WAIT;
        seen_d  = seen_q | bus.chk_fire[idx_q];
      end
      S_WAIT: begin
        seen_d = seen_q | bus.chk_fire[idx_q];
        if (cnt_q == WAIT_LAST) state_d = S_NEXT;
      end
      S_NEXT: begin
        fail_mask_d[idx_q] = fail_mask_q[idx_q] | (seen_q ^ inject_q[idx_q]);
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RST;
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (SPURIOUS_EN && (state_q == S_EDGE || state_q == S_WAIT)) begin
      for (int j = 0; j < NUM_CHK; j++) begin
        if (j != int'(idx_q) && bus.chk_fire[j]) fail_mask_d[j] = 1'b1;
      end
    end

    // Every state entry restarts the cycle counter.
    if (state_d != state_q) cnt_d = '0;
  end

  assign active_d  = (state_d == S_RST) || (state_d == S_PRE) || (state_d == S_EDGE) ||
                     (state_d == S_WAIT) || (state_d == S_NEXT);
  // done/pass follow the settled mask one cycle after the final NEXT write.
  assign stay_done = (state_q == S_DONE) && (state_d == S_DONE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      idx_q            <= '0;
      inject_q         <= '0;
      seen_q           <= 1'b0;
      fail_mask_q      <= '0;
      chk_rst_n_q      <= 1'b0;
      chk_enable_q     <= '0;
      sampling_event_q <= 1'b0;
      test_expr_q      <= 1'b1;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      idx_q            <= idx_d;
      inject_q         <= inject_d;
      seen_q           <= seen_d;
      fail_mask_q      <= fail_mask_d;
      chk_rst_n_q      <= (state_d != S_RST);
      chk_enable_q     <= active_d ? (NUM_CHK'(1) << idx_d) : '0;
      sampling_event_q <= (state_d == S_EDGE);
      test_expr_q      <= (state_d == S_EDGE) ? ~inject_d[idx_d] : 1'b1;
      busy_q           <= active_d;
      done_q           <= stay_done;
      pass_q           <= stay_done && (fail_mask_q == '0);
    end
  end

  assign bus.chk_rst_n      = chk_rst_n_q;
  assign bus.chk_enable     = chk_enable_q;
  assign bus.sampling_event = sampling_event_q;
  assign bus.test_expr      = test_expr_q;
  assign bus.cur_idx        = idx_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.fail_mask      = fail_mask_q;
  assign bus.state_dbg      = state_q;
endmodule

// File: tb/tb_ovl_sem_edge_sequencer.sv
// Bench for ovl_sem_edge_sequencer: directed and random sweeps against a slot-timing model.
module tb_ovl_sem_edge_sequencer;
  localparam int NUM_CHK     = 4;
  localparam int RST_CYCLES  = 2;
  localparam int WAIT_CYCLES = 3;
  localparam int SLOT        = RST_CYCLES + WAIT_CYCLES + 3;
  localparam int SWEEP       = NUM_CHK * SLOT;
  localparam int EDGE_OFF    = RST_CYCLES + 1;
  localparam int TAIL        = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ovl_sem_edge_sequencer_if #(.NUM_CHK(NUM_CHK)) bus ();

  ovl_sem_edge_sequencer #(
    .NUM_CHK    (NUM_CHK),
    .RST_CYCLES (RST_CYCLES),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [NUM_CHK-1:0] exp_q[$];
  logic [NUM_CHK-1:0] sched [0:SWEEP+TAIL-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: each checker owns a SLOT-cycle window after the accepting edge; its
  // fire counts only in the EDGE cycle and the WAIT_CYCLES cycles after it.
  function automatic logic [NUM_CHK-1:0] model_mask(input logic [NUM_CHK-1:0] inj);
    logic [NUM_CHK-1:0] m;
    logic seen;
    m = '0;
    for (int k = 0; k < NUM_CHK; k++) begin
      seen = 1'b0;
      for (int off = EDGE_OFF; off <= EDGE_OFF + WAIT_CYCLES; off++) begin
        seen = seen | sched[k*SLOT + off][k];
`ifdef OVL_SEM_SEQ_SPURIOUS_CHK_EN
        for (int j = 0; j < NUM_CHK; j++)
          if (j != k && sched[k*SLOT + off][j]) m[j] = 1'b1;
`endif
      end
      if (seen != inj[k]) m[k] = 1'b1;
    end
    return m;
  endfunction

  task automatic clear_sched();
    for (int c = 0; c < SWEEP + TAIL; c++) sched[c] = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq(tag,
      {bus.chk_rst_n, bus.chk_enable, bus.sampling_event, bus.test_expr, bus.cur_idx,
       bus.busy, bus.done, bus.pass, bus.fail_mask},
      {1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000});
  endtask

  // abort_at >= 0 raises reset at that cycle of the sweep and checks the abort.
  task automatic run_sweep(input string name, input logic [NUM_CHK-1:0] inj,
                           input bit poke_start, input int abort_at);
    logic [NUM_CHK-1:0] exp_mask;
    logic [NUM_CHK-1:0] en;
    int k, off;
    exp_q.push_back(model_mask(inj));
    @(negedge clk);
    bus.start  = 1'b1;
    bus.inject = inj;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.inject = NUM_CHK'($urandom);
    exp_mask   = exp_q.pop_front();
    for (int c = 0; c < SWEEP + TAIL; c++) begin
      bus.chk_fire = sched[c];
      if (c == abort_at) begin
        reset = 1'b1;
        #1;
        check_reset_values($sformatf("%s abort c=%0d", name, c));
        bus.chk_fire = '0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (c < SWEEP) begin
        k   = c / SLOT;
        off = c % SLOT;
        en  = NUM_CHK'(1) << k;
        check_eq($sformatf("%s outputs c=%0d", name, c),
          {bus.cur_idx, bus.chk_enable, bus.chk_rst_n, bus.sampling_event, bus.test_expr,
           bus.busy, bus.done},
          {2'(k), en, 1'(off >= RST_CYCLES), 1'(off == EDGE_OFF),
           (off == EDGE_OFF) ? ~inj[k] : 1'b1, 1'b1, 1'b0});
      end else if (c == SWEEP) begin
        check_eq($sformatf("%s final-slot end c=%0d", name, c),
          {bus.busy, bus.done, bus.chk_enable, bus.chk_rst_n},
          {1'b0, 1'b0, 4'b0000, 1'b1});
      end else begin
        check_eq($sformatf("%s done c=%0d", name, c),
          {bus.busy, bus.done, bus.pass, bus.fail_mask},
          {1'b0, 1'b1, 1'(exp_mask == '0), exp_mask});
      end
      if (poke_start && c == 10) begin
        bus.start  = 1'b1;
        bus.inject = ~inj;
      end else begin
        bus.start  = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus.chk_fire = '0;
  endtask

  initial begin
    logic [NUM_CHK-1:0] inj;
    int c0;
    bus.start    = 1'b0;
    bus.inject   = '0;
    bus.chk_fire = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset values");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle after reset", {bus.chk_rst_n, bus.busy, bus.done, bus.chk_enable},
             {1'b1, 1'b0, 1'b0, 4'b0000});

    clear_sched();
    run_sweep("clean", 4'b0000, 1'b0, -1);

    clear_sched();
    sched[0*SLOT + EDGE_OFF + 1][0] = 1'b1;
    sched[2*SLOT + EDGE_OFF + 1][2] = 1'b1;
    run_sweep("expected", 4'b0101, 1'b0, -1);

    clear_sched();
    run_sweep("missed", 4'b0010, 1'b0, -1);

    clear_sched();
    sched[3*SLOT + EDGE_OFF + 2][3] = 1'b1;
    run_sweep("spurious", 4'b0000, 1'b0, -1);

    clear_sched();
    sched[0*SLOT + EDGE_OFF + 1][2] = 1'b1;
    run_sweep("cross", 4'b0000, 1'b0, -1);

    clear_sched();
    sched[0*SLOT + 1][0]        = 1'b1;
    sched[0*SLOT + 2][0]        = 1'b1;
    sched[1*SLOT + SLOT - 1][1] = 1'b1;
    run_sweep("outside window", 4'b0011, 1'b0, -1);

    clear_sched();
    sched[0*SLOT + EDGE_OFF][0]               = 1'b1;
    sched[3*SLOT + EDGE_OFF + WAIT_CYCLES][3] = 1'b1;
    run_sweep("window edges", 4'b1001, 1'b0, -1);

    clear_sched();
    run_sweep("abort", 4'b0001, 1'b0, 2*SLOT + EDGE_OFF + 2);
    clear_sched();
    run_sweep("after abort", 4'b0000, 1'b0, -1);

    for (int r = 0; r < 8; r++) begin
      clear_sched();
      inj = NUM_CHK'($urandom);
      for (int k = 0; k < NUM_CHK; k++) begin
        if ($urandom_range(0, 2) != 0) begin
          c0 = k*SLOT + int'($urandom_range(0, SLOT - 1));
          sched[c0][k] = 1'b1;
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        c0 = int'($urandom_range(0, SWEEP - 1));
        sched[c0][$urandom_range(0, NUM_CHK - 1)] = 1'b1;
      end
      run_sweep($sformatf("random%0d", r), inj, (r == 0), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
